cpu_ad48: RTL and testbench

CPU_AD48 -- requirements
Module: cpu_ad48

---
 rtl/cpu_ad48.sv | 131 +++++++++++++
 tb/tb_cpu_ad48.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ad48.sv
// CPU_AD48: single-cycle 48-bit load/store core with sixteen registers,
// combinational-read instruction/data memories and a sticky halt.

module cpu_ad48_mem #(
  parameter int WORDS = 1024
) (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [47:0] wdata,
  output logic [47:0] rdata
);
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [47:0] mem [0:WORDS-1];
  logic        in_range;

  // Out-of-range addresses read as zero and swallow writes.
  assign in_range = (addr < 32'(WORDS));
  assign rdata    = in_range ? mem[addr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (we && in_range) mem[addr[AW-1:0]] <= wdata;
  end
endmodule

module cpu_ad48 #(
  parameter int IM_WORDS = 1024,
  parameter int DM_WORDS = 1024
) (
  input logic clk,
  input logic resetn
);
  localparam int DATA_W = 48;

  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_AND  = 8'h03;
  localparam logic [7:0] OP_OR   = 8'h04;
  localparam logic [7:0] OP_XOR  = 8'h05;
  localparam logic [7:0] OP_ADDI = 8'h06;
  localparam logic [7:0] OP_LUI  = 8'h07;
  localparam logic [7:0] OP_LD   = 8'h10;
  localparam logic [7:0] OP_ST   = 8'h11;
  localparam logic [7:0] OP_BEQ  = 8'h20;
  localparam logic [7:0] OP_BNE  = 8'h21;
  localparam logic [7:0] OP_JMP  = 8'h22;
  localparam logic [7:0] OP_HALT = 8'h3F;

  logic [31:0]              pc;
  logic                     halt;
  logic signed [DATA_W-1:0] regs [0:15];

  logic [47:0]              instr;
  logic [47:0]              dm_rdata;
  logic [7:0]               op;
  logic [3:0]               rd, rs, rt;
  logic signed [DATA_W-1:0] imm, rs_val, rt_val, sum, wb_val;
  logic                     wb_en, dm_we, halt_now;
  logic [31:0]              pc_next;
  logic                     unused_bits;

  function automatic logic signed [DATA_W-1:0] sext24(input logic [23:0] v);
    return {{(DATA_W-24){v[23]}}, v};
  endfunction

  cpu_ad48_mem #(.WORDS(IM_WORDS)) IMEM (
    .clk   (clk),
    .we    (1'b0),
    .addr  (pc),
    .wdata ('0),
    .rdata (instr)
  );

  cpu_ad48_mem #(.WORDS(DM_WORDS)) DMEM (
    .clk   (clk),
    .we    (dm_we),
    .addr  (sum[31:0]),
    .wdata (rt_val),
    .rdata (dm_rdata)
  );

  assign op     = instr[47:40];
  assign rd     = instr[39:36];
  assign rs     = instr[35:32];
  assign rt     = instr[31:28];
  assign imm    = sext24(instr[23:0]);
  // regs[0] is never written, so it always reads back its reset value of zero.
  assign rs_val = regs[rs];
  assign rt_val = regs[rt];
  assign sum    = rs_val + imm;

  // Stores are gated by halt and by reset so an interrupted store never lands.
  assign dm_we  = (op == OP_ST) && !halt && resetn;

  assign unused_bits = &{1'b0, instr[27:24], sum[47:32]};

  always_comb begin
    wb_en    = 1'b0;
    wb_val   = '0;
    halt_now = 1'b0;
    pc_next  = pc + 32'd1;
    case (op)
      OP_ADD:  begin wb_en = 1'b1; wb_val = rs_val + rt_val; end
      OP_SUB:  begin wb_en = 1'b1; wb_val = rs_val - rt_val; end
      OP_AND:  begin wb_en = 1'b1; wb_val = rs_val & rt_val; end
      OP_OR:   begin wb_en = 1'b1; wb_val = rs_val | rt_val; end
      OP_XOR:  begin wb_en = 1'b1; wb_val = rs_val ^ rt_val; end
      OP_ADDI: begin wb_en = 1'b1; wb_val = sum; end
      OP_LUI:  begin wb_en = 1'b1; wb_val = {instr[23:0], 24'd0}; end
      OP_LD:   begin wb_en = 1'b1; wb_val = dm_rdata; end
      OP_BEQ:  if (rs_val == rt_val) pc_next = pc + imm[31:0];
      OP_BNE:  if (rs_val != rt_val) pc_next = pc + imm[31:0];
      OP_JMP:  pc_next = {8'd0, instr[23:0]};
      OP_HALT: begin halt_now = 1'b1; pc_next = pc; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc   <= '0;
      halt <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (!halt) begin
      pc <= pc_next;
      if (halt_now) halt <= 1'b1;
      if (wb_en && (rd != 4'd0)) regs[rd] <= wb_val;
    end
  end
endmodule

// File: tb/tb_cpu_ad48.sv
// Bench for cpu_ad48: directed program table, random programs against an
// instruction-level interpreter, and a mid-program reset sequence.

module tb_cpu_ad48;
  localparam int IMW = 32;
  localparam int DMW = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  cpu_ad48 #(.IM_WORDS(IMW), .DM_WORDS(DMW)) dut (
    .clk    (clk),
    .resetn (resetn)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;

  typedef struct packed {
    logic [0:IMW-1][47:0] prog;
    int          da;
    logic [47:0] dv;
    int          ca;
    logic [47:0] cv;
    int          cr;
    logic [47:0] crv;
    logic [31:0] epc;
    logic        eh;
    int          ecyc;
  } vec_t;

  vec_t vt [9];

  logic [47:0] mi [IMW];
  logic [47:0] md [DMW];
  logic [47:0] mr [16];
  logic [31:0] mpc;
  bit          mh;

  function automatic logic [47:0] enc(logic [7:0] op, int rd, int rs, int rt, int imm);
    return {op, 4'(rd), 4'(rs), 4'(rt), 4'b0, 24'(imm)};
  endfunction

  function automatic logic [47:0] fill(int a);
    return 48'h0A5A_0000_0000 + 48'(a * 7 + 1);
  endfunction

  task automatic chk(string nm, logic [47:0] act, logic [47:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Instruction-level interpreter: one architectural step per call.
  task automatic mstep();
    logic [47:0] ins, a, b, imm, ea, res;
    logic [31:0] npc;
    bit wr;
    int r;
    if (mh) return;
    ins = (mpc < IMW) ? mi[mpc[4:0]] : 48'd0;
    a   = mr[ins[35:32]];
    b   = mr[ins[31:28]];
    imm = {{24{ins[23]}}, ins[23:0]};
    ea  = a + imm;
    npc = mpc + 32'd1;
    res = '0;
    wr  = 0;
    r   = int'(ins[39:36]);
    case (ins[47:40])
      8'h01: begin res = a + b; wr = 1; end
      8'h02: begin res = a - b; wr = 1; end
      8'h03: begin res = a & b; wr = 1; end
      8'h04: begin res = a | b; wr = 1; end
      8'h05: begin res = a ^ b; wr = 1; end
      8'h06: begin res = ea; wr = 1; end
      8'h07: begin res = {ins[23:0], 24'd0}; wr = 1; end
      8'h10: begin res = (ea[31:0] < DMW) ? md[ea[3:0]] : 48'd0; wr = 1; end
      8'h11: if (ea[31:0] < DMW) md[ea[3:0]] = b;
      8'h20: if (a == b) npc = mpc + imm[31:0];
      8'h21: if (a != b) npc = mpc + imm[31:0];
      8'h22: npc = {8'd0, ins[23:0]};
      8'h3F: begin mh = 1; npc = mpc; end
      default: ;
    endcase
    if (wr && r != 0) mr[r] = res;
    mpc = npc;
  endtask

  task automatic load_dut();
    for (int i = 0; i < IMW; i++) dut.IMEM.mem[i] = mi[i];
    for (int i = 0; i < DMW; i++) dut.DMEM.mem[i] = md[i];
  endtask

  task automatic run_dut(input int ncyc, output int hcyc);
    resetn = 1'b0;
    #1;
    chk("reset_pc", {16'd0, dut.pc}, 48'd0);
    chk("reset_halt", {47'd0, dut.halt}, 48'd0);
    chk("reset_r1", dut.regs[1], 48'd0);
    load_dut();
    @(negedge clk);
    resetn = 1'b1;
    hcyc = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (dut.halt && hcyc == 0) hcyc = c;
    end
  endtask

  task automatic rand_instr(output logic [47:0] w);
    logic [7:0] ops [16];
    logic [7:0] op;
    int imm;
    ops = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
            8'h10, 8'h11, 8'h20, 8'h21, 8'h22, 8'h3F, 8'h00, 8'h06};
    op = ops[$urandom_range(0, 15)];
    if ($urandom_range(0, 15) == 0) op = 8'($urandom());
    if ($urandom_range(0, 3) == 0) imm = int'($urandom() & 32'h00FF_FFFF);
    else imm = int'($urandom_range(0, 40)) - 8;
    w = enc(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), imm);
  endtask

  initial begin
    int hc;
    logic [63:0] t;

    for (int v = 0; v < 9; v++) begin
      vt[v] = '0;
      vt[v].da = -1;
      vt[v].cv = fill(0);
      vt[v].eh = 1'b1;
    end
    // Lone HALT; the following ADDI must never run.
    vt[0].prog[0] = enc(8'h3F, 0, 0, 0, 0);
    vt[0].prog[1] = enc(8'h06, 1, 0, 0, 1);
    vt[0].cr = 1; vt[0].crv = 0; vt[0].epc = 0; vt[0].ecyc = 1;
    // ADDI/ADDI/ADD/ST.
    vt[1].prog[0] = enc(8'h06, 1, 0, 0, 5);
    vt[1].prog[1] = enc(8'h06, 2, 0, 0, -3);
    vt[1].prog[2] = enc(8'h01, 3, 1, 2, 0);
    vt[1].prog[3] = enc(8'h11, 0, 0, 3, 8);
    vt[1].prog[4] = enc(8'h3F, 0, 0, 0, 0);
    vt[1].ca = 8; vt[1].cv = 48'd2; vt[1].cr = 3; vt[1].crv = 48'd2;
    vt[1].epc = 4; vt[1].ecyc = 5;
    // Load all-ones, add one, wrap to zero.
    vt[2].da = 3; vt[2].dv = 48'hFFFF_FFFF_FFFF;
    vt[2].prog[0] = enc(8'h10, 1, 0, 0, 3);
    vt[2].prog[1] = enc(8'h06, 1, 1, 0, 1);
    vt[2].prog[2] = enc(8'h11, 0, 0, 1, 4);
    vt[2].prog[3] = enc(8'h3F, 0, 0, 0, 0);
    vt[2].ca = 4; vt[2].cv = 48'd0; vt[2].cr = 1; vt[2].crv = 48'd0;
    vt[2].epc = 3; vt[2].ecyc = 4;
    // Countdown loop, BNE taken twice.
    vt[3].prog[0] = enc(8'h06, 1, 0, 0, 3);
    vt[3].prog[1] = enc(8'h06, 1, 1, 0, -1);
    vt[3].prog[2] = enc(8'h21, 0, 1, 0, -1);
    vt[3].prog[3] = enc(8'h3F, 0, 0, 0, 0);
    vt[3].cr = 1; vt[3].crv = 48'd0; vt[3].epc = 3; vt[3].ecyc = 8;
    // JMP over a store.
    vt[4].prog[0] = enc(8'h06, 1, 0, 0, 7);
    vt[4].prog[1] = enc(8'h22, 0, 0, 0, 10);
    vt[4].prog[2] = enc(8'h11, 0, 0, 1, 2);
    vt[4].prog[10] = enc(8'h3F, 0, 0, 0, 0);
    vt[4].ca = 2; vt[4].cv = fill(2); vt[4].cr = 1; vt[4].crv = 48'd7;
    vt[4].epc = 10; vt[4].ecyc = 3;
    // LUI/OR and an undefined opcode that must not write R1.
    vt[5].prog[0] = enc(8'h06, 1, 0, 0, 'h0F0F);
    vt[5].prog[1] = enc(8'h07, 2, 0, 0, 'h123456);
    vt[5].prog[2] = enc(8'h04, 3, 1, 2, 0);
    vt[5].prog[3] = enc(8'h11, 0, 0, 3, 1);
    vt[5].prog[4] = enc(8'h0A, 1, 3, 3, 0);
    vt[5].prog[5] = enc(8'h3F, 0, 0, 0, 0);
    vt[5].ca = 1; vt[5].cv = 48'h1234_5600_0F0F; vt[5].cr = 1; vt[5].crv = 48'h0F0F;
    vt[5].epc = 5; vt[5].ecyc = 6;
    // Out-of-range store ignored, out-of-range load returns zero.
    vt[6].prog[0] = enc(8'h06, 1, 0, 0, 99);
    vt[6].prog[1] = enc(8'h06, 2, 0, 0, 1);
    vt[6].prog[2] = enc(8'h11, 0, 0, 1, 20);
    vt[6].prog[3] = enc(8'h10, 2, 0, 0, 16);
    vt[6].prog[4] = enc(8'h3F, 0, 0, 0, 0);
    vt[6].ca = 4; vt[6].cv = fill(4); vt[6].cr = 2; vt[6].crv = 48'd0;
    vt[6].epc = 4; vt[6].ecyc = 5;
    // SUB with -1 and a taken BEQ skipping an ADDI.
    vt[7].prog[0] = enc(8'h06, 1, 0, 0, -1);
    vt[7].prog[1] = enc(8'h06, 2, 0, 0, 'h30);
    vt[7].prog[2] = enc(8'h02, 3, 2, 1, 0);
    vt[7].prog[3] = enc(8'h11, 0, 0, 3, 6);
    vt[7].prog[4] = enc(8'h02, 5, 0, 1, 0);
    vt[7].prog[5] = enc(8'h20, 0, 5, 5, 2);
    vt[7].prog[6] = enc(8'h06, 5, 0, 0, 9);
    vt[7].prog[7] = enc(8'h3F, 0, 0, 0, 0);
    vt[7].ca = 6; vt[7].cv = 48'h31; vt[7].cr = 5; vt[7].crv = 48'd1;
    vt[7].epc = 7; vt[7].ecyc = 7;
    // Run off the end of IMEM: fetches become NOPs, no halt.
    vt[8].prog[0] = enc(8'h22, 0, 0, 0, 31);
    vt[8].prog[31] = enc(8'h06, 1, 0, 0, 1);
    vt[8].cr = 1; vt[8].crv = 48'd1; vt[8].epc = 60; vt[8].eh = 1'b0; vt[8].ecyc = 0;

    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < IMW; i++) mi[i] = vt[v].prog[i];
      for (int i = 0; i < DMW; i++) md[i] = fill(i);
      if (vt[v].da >= 0) md[vt[v].da] = vt[v].dv;
      run_dut(30, hc);
      chk($sformatf("v%0d_pc", v), {16'd0, dut.pc}, {16'd0, vt[v].epc});
      chk($sformatf("v%0d_halt", v), {47'd0, dut.halt}, {47'd0, vt[v].eh});
      chk($sformatf("v%0d_halt_cycle", v), 48'(hc), 48'(vt[v].ecyc));
      chk($sformatf("v%0d_reg", v), dut.regs[vt[v].cr], vt[v].crv);
      chk($sformatf("v%0d_dmem", v), dut.DMEM.mem[vt[v].ca], vt[v].cv);
    end

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < IMW; i++) rand_instr(mi[i]);
      for (int i = 0; i < DMW; i++) begin
        t = {$urandom(), $urandom()};
        md[i] = ($urandom_range(0, 1) == 0) ? t[47:0] : 48'($urandom_range(0, 20));
      end
      for (int i = 0; i < 16; i++) mr[i] = '0;
      mpc = '0;
      mh = 0;
      run_dut(40, hc);
      for (int s = 0; s < 40; s++) mstep();
      chk($sformatf("rnd%0d_pc", n), {16'd0, dut.pc}, {16'd0, mpc});
      chk($sformatf("rnd%0d_halt", n), {47'd0, dut.halt}, {47'd0, mh});
      for (int i = 1; i < 16; i++)
        chk($sformatf("rnd%0d_r%0d", n, i), dut.regs[i], mr[i]);
      for (int i = 0; i < DMW; i++)
        chk($sformatf("rnd%0d_d%0d", n, i), dut.DMEM.mem[i], md[i]);
    end

    // Reset pulsed mid-loop, then the program reruns to the same result.
    for (int i = 0; i < IMW; i++) mi[i] = '0;
    mi[0] = enc(8'h06, 1, 0, 0, 20);
    mi[1] = enc(8'h06, 2, 2, 0, 1);
    mi[2] = enc(8'h06, 1, 1, 0, -1);
    mi[3] = enc(8'h21, 0, 1, 0, -2);
    mi[4] = enc(8'h11, 0, 0, 2, 5);
    mi[5] = enc(8'h3F, 0, 0, 0, 0);
    for (int i = 0; i < DMW; i++) md[i] = fill(i);
    run_dut(15, hc);
    chk("mid_running", {47'd0, dut.halt}, 48'd0);
    #2 resetn = 1'b0;
    #1;
    chk("mid_reset_pc", {16'd0, dut.pc}, 48'd0);
    chk("mid_reset_halt", {47'd0, dut.halt}, 48'd0);
    chk("mid_reset_r2", dut.regs[2], 48'd0);
    chk("mid_reset_dmem5", dut.DMEM.mem[5], fill(5));
    chk("mid_reset_imem1", dut.IMEM.mem[1], mi[1]);
    @(negedge clk);
    resetn = 1'b1;
    hc = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (dut.halt && hc == 0) hc = c;
    end
    chk("rerun_halt_cycle", 48'(hc), 48'd63);
    chk("rerun_pc", {16'd0, dut.pc}, 48'd5);
    chk("rerun_dmem5", dut.DMEM.mem[5], 48'd20);
    chk("rerun_r1", dut.regs[1], 48'd0);
    chk("rerun_r2", dut.regs[2], 48'd20);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
